// File: rtl/ycbcr_multi_threshold_pkg.sv
// Shared constants for the YCbCr multi-class threshold stage: field encodings,
// ctrl bit positions and the power-on threshold set.
package ycbcr_multi_threshold_pkg;

   localparam int unsigned FLD_W   = 3;
   localparam int unsigned NUM_THR = 6;
   localparam int unsigned CTRL_W  = 2;

   localparam logic [FLD_W-1:0] FLD_Y_LO  = 3'd0;
   localparam logic [FLD_W-1:0] FLD_Y_HI  = 3'd1;
   localparam logic [FLD_W-1:0] FLD_CB_LO = 3'd2;
   localparam logic [FLD_W-1:0] FLD_CB_HI = 3'd3;
   localparam logic [FLD_W-1:0] FLD_CR_LO = 3'd4;
   localparam logic [FLD_W-1:0] FLD_CR_HI = 3'd5;
   localparam logic [FLD_W-1:0] FLD_CTRL  = 3'd6;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_YEN_BIT = 1;

   localparam int unsigned Y_LO_DEF  = 'h00;
   localparam int unsigned Y_HI_DEF  = 'hFF;
   localparam int unsigned CB_LO_DEF = 'h00;
   localparam int unsigned CB_HI_DEF = 'hFF;
   localparam int unsigned CR_LO_DEF = 'hAF;
   localparam int unsigned CR_HI_DEF = 'hFF;
   localparam int unsigned CTRL_DEF  = 'h01;

   // Reset value of one field for one class; only class 0 has a non-zero set.
   function automatic int unsigned thr_default(input int unsigned cls, input int unsigned fld);
      if (cls != 0) return 0;
      case (fld)
         0:       return Y_LO_DEF;
         1:       return Y_HI_DEF;
         2:       return CB_LO_DEF;
         3:       return CB_HI_DEF;
         4:       return CR_LO_DEF;
         5:       return CR_HI_DEF;
         default: return CTRL_DEF;
      endcase
   endfunction

endpackage

// File: rtl/ycbcr_window_cmp.sv
// One class: shadow/active threshold banks committed at frame start, plus the
// strict Y/Cb/Cr window compare registered as the stage-1 hit.
module ycbcr_window_cmp
   import ycbcr_multi_threshold_pkg::*;
#(
   parameter int unsigned DW        = 8,
   parameter int unsigned CLASS_IDX = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vsync_rise_i,
   input  logic             cfg_wr_i,
   input  logic [FLD_W-1:0] cfg_field_i,
   input  logic [DW-1:0]    cfg_data_i,
   input  logic             de_i,
   input  logic [DW-1:0]    y_i,
   input  logic [DW-1:0]    cb_i,
   input  logic [DW-1:0]    cr_i,
   output logic             hit_o,
   output logic             en_o
);

   function automatic logic [NUM_THR-1:0][DW-1:0] thr_reset();
      logic [NUM_THR-1:0][DW-1:0] r;
      for (int unsigned f = 0; f < NUM_THR; f++) begin
         r[f] = DW'(thr_default(CLASS_IDX, f));
      end
      return r;
   endfunction

   localparam logic [NUM_THR-1:0][DW-1:0] THR_RST  = thr_reset();
   localparam logic [CTRL_W-1:0]          CTRL_RST = CTRL_W'(thr_default(CLASS_IDX, NUM_THR));

   logic [NUM_THR-1:0][DW-1:0] shd_thr_q, shd_thr_d;
   logic [NUM_THR-1:0][DW-1:0] act_thr_q, act_thr_d;
   logic [CTRL_W-1:0]          shd_ctrl_q, shd_ctrl_d;
   logic [CTRL_W-1:0]          act_ctrl_q, act_ctrl_d;
   logic                       hit_q, hit_d;
   logic                       en_q, en_d;

   function automatic logic in_win(input logic [DW-1:0] lo, input logic [DW-1:0] v,
                                   input logic [DW-1:0] hi);
      return (lo < v) && (v < hi);
   endfunction

   // Active bank loads the pre-write shadow contents, so a write landing on
   // the commit cycle waits for the following frame start.
   always_comb begin
      shd_thr_d  = shd_thr_q;
      shd_ctrl_d = shd_ctrl_q;
      act_thr_d  = act_thr_q;
      act_ctrl_d = act_ctrl_q;
      if (cfg_wr_i) begin
         for (int unsigned f = 0; f < NUM_THR; f++) begin
            if (cfg_field_i == FLD_W'(f)) shd_thr_d[f] = cfg_data_i;
         end
         if (cfg_field_i == FLD_CTRL) shd_ctrl_d = cfg_data_i[CTRL_W-1:0];
      end
      if (vsync_rise_i) begin
         act_thr_d  = shd_thr_q;
         act_ctrl_d = shd_ctrl_q;
      end
      en_d  = act_ctrl_q[CTRL_EN_BIT];
      hit_d = de_i & act_ctrl_q[CTRL_EN_BIT]
            & in_win(act_thr_q[FLD_CB_LO], cb_i, act_thr_q[FLD_CB_HI])
            & in_win(act_thr_q[FLD_CR_LO], cr_i, act_thr_q[FLD_CR_HI])
            & (~act_ctrl_q[CTRL_YEN_BIT] | in_win(act_thr_q[FLD_Y_LO], y_i, act_thr_q[FLD_Y_HI]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_thr_q  <= THR_RST;
         act_thr_q  <= THR_RST;
         shd_ctrl_q <= CTRL_RST;
         act_ctrl_q <= CTRL_RST;
         hit_q      <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         shd_thr_q  <= shd_thr_d;
         act_thr_q  <= act_thr_d;
         shd_ctrl_q <= shd_ctrl_d;
         act_ctrl_q <= act_ctrl_d;
         hit_q      <= hit_d;
         en_q       <= en_d;
      end
   end

   assign hit_o = hit_q;
   assign en_o  = en_q;

endmodule

// File: rtl/ycbcr_multi_threshold.sv
// Colour segmentation: per-class window hits combined into a mono mask, with a
// 2-cycle sync delay line and per-frame saturating hit counters.
module ycbcr_multi_threshold
   import ycbcr_multi_threshold_pkg::*;
#(
   parameter int unsigned DW        = 8,
   parameter int unsigned NUM_CLASS = 2,
   parameter int unsigned CNT_W     = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ycbcr_vsync,
   input  logic                       ycbcr_hsync,
   input  logic                       ycbcr_de,
   input  logic [DW-1:0]              luminance,
   input  logic [DW-1:0]              cb_data,
   input  logic [DW-1:0]              cr_data,
   input  logic                       cfg_wr,
   input  logic [2:0]                 cfg_class,
   input  logic [FLD_W-1:0]           cfg_field,
   input  logic [DW-1:0]              cfg_data,
   input  logic                       combine_all,
   output logic                       post_vsync,
   output logic                       post_hsync,
   output logic                       post_de,
   output logic                       monoc,
   output logic [NUM_CLASS-1:0]       class_hit,
   output logic [NUM_CLASS*CNT_W-1:0] hit_cnt,
   output logic                       frame_done
);

   logic [2:0]                      sync_s1_q, sync_s1_d;
   logic [2:0]                      sync_s2_q, sync_s2_d;
   logic                            comb_s1_q, comb_s1_d;
   logic [NUM_CLASS-1:0]            class_hit_q, class_hit_d;
   logic                            monoc_q, monoc_d;
   logic [NUM_CLASS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_CLASS-1:0][CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic                            frame_done_q, frame_done_d;

   logic                            vsync_rise_c;
   logic [NUM_CLASS-1:0]            cls_wr_c;
   logic [NUM_CLASS-1:0]            hit_s1;
   logic [NUM_CLASS-1:0]            en_s1;
   logic                            any_en_c;
   logic                            all_hit_c;

   assign vsync_rise_c = ycbcr_vsync & ~sync_s1_q[2];

   for (genvar g = 0; g < NUM_CLASS; g++) begin : g_cls
      assign cls_wr_c[g] = cfg_wr & (cfg_class == 3'(g));

      ycbcr_window_cmp #(
         .DW        (DW),
         .CLASS_IDX (g)
      ) u_cmp (
         .clk          (clk),
         .rst_n        (rst_n),
         .vsync_rise_i (vsync_rise_c),
         .cfg_wr_i     (cls_wr_c[g]),
         .cfg_field_i  (cfg_field),
         .cfg_data_i   (cfg_data),
         .de_i         (ycbcr_de),
         .y_i          (luminance),
         .cb_i         (cb_data),
         .cr_i         (cr_data),
         .hit_o        (hit_s1[g]),
         .en_o         (en_s1[g])
      );
   end

   // AND mode ignores disabled classes; with nothing enabled the mask is black.
   assign any_en_c  = |en_s1;
   assign all_hit_c = &(hit_s1 | ~en_s1);

   always_comb begin
      sync_s1_d    = {ycbcr_vsync, ycbcr_hsync, ycbcr_de};
      sync_s2_d    = sync_s1_q;
      comb_s1_d    = combine_all;
      class_hit_d  = hit_s1;
      monoc_d      = comb_s1_q ? (any_en_c & all_hit_c) : |hit_s1;
      cnt_d        = cnt_q;
      hit_cnt_d    = hit_cnt_q;
      frame_done_d = vsync_rise_c;
      // A stage-1 hit in the commit cycle belongs to the new frame.
      for (int unsigned k = 0; k < NUM_CLASS; k++) begin
         if (vsync_rise_c) begin
            hit_cnt_d[k] = cnt_q[k];
            cnt_d[k]     = CNT_W'(hit_s1[k]);
         end else if (hit_s1[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_s1_q    <= '0;
         sync_s2_q    <= '0;
         comb_s1_q    <= 1'b0;
         class_hit_q  <= '0;
         monoc_q      <= 1'b0;
         cnt_q        <= '0;
         hit_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         sync_s1_q    <= sync_s1_d;
         sync_s2_q    <= sync_s2_d;
         comb_s1_q    <= comb_s1_d;
         class_hit_q  <= class_hit_d;
         monoc_q      <= monoc_d;
         cnt_q        <= cnt_d;
         hit_cnt_q    <= hit_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign post_vsync = sync_s2_q[2];
   assign post_hsync = sync_s2_q[1];
   assign post_de    = sync_s2_q[0];
   assign monoc      = monoc_q;
   assign class_hit  = class_hit_q;
   assign hit_cnt    = hit_cnt_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ycbcr_multi_threshold.sv
// Bench for ycbcr_multi_threshold: vector table, hand-written frame sequences
// and randomized traffic against a behavioural model (CNT_W=20 and CNT_W=4).
module tb_ycbcr_multi_threshold;

   localparam int NC  = 2;
   localparam int CW  = 20;
   localparam int CWS = 4;
   localparam int MAX20 = (1 << CW) - 1;
   localparam int MAX4  = (1 << CWS) - 1;

   logic clk;
   logic rst_n;
   logic ycbcr_vsync, ycbcr_hsync, ycbcr_de;
   logic [7:0] luminance, cb_data, cr_data;
   logic cfg_wr;
   logic [2:0] cfg_class, cfg_field;
   logic [7:0] cfg_data;
   logic combine_all;

   logic post_vsync, post_hsync, post_de, monoc, frame_done;
   logic [NC-1:0] class_hit;
   logic [NC*CW-1:0] hit_cnt;
   logic post_vsync_s, post_hsync_s, post_de_s, monoc_s, frame_done_s;
   logic [NC-1:0] class_hit_s;
   logic [NC*CWS-1:0] hit_cnt_s;

   ycbcr_multi_threshold #(.DW(8), .NUM_CLASS(NC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ycbcr_vsync(ycbcr_vsync), .ycbcr_hsync(ycbcr_hsync), .ycbcr_de(ycbcr_de),
      .luminance(luminance), .cb_data(cb_data), .cr_data(cr_data),
      .cfg_wr(cfg_wr), .cfg_class(cfg_class), .cfg_field(cfg_field), .cfg_data(cfg_data),
      .combine_all(combine_all),
      .post_vsync(post_vsync), .post_hsync(post_hsync), .post_de(post_de),
      .monoc(monoc), .class_hit(class_hit), .hit_cnt(hit_cnt), .frame_done(frame_done));

   ycbcr_multi_threshold #(.DW(8), .NUM_CLASS(NC), .CNT_W(CWS)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .ycbcr_vsync(ycbcr_vsync), .ycbcr_hsync(ycbcr_hsync), .ycbcr_de(ycbcr_de),
      .luminance(luminance), .cb_data(cb_data), .cr_data(cr_data),
      .cfg_wr(cfg_wr), .cfg_class(cfg_class), .cfg_field(cfg_field), .cfg_data(cfg_data),
      .combine_all(combine_all),
      .post_vsync(post_vsync_s), .post_hsync(post_hsync_s), .post_de(post_de_s),
      .monoc(monoc_s), .class_hit(class_hit_s), .hit_cnt(hit_cnt_s), .frame_done(frame_done_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          vs;
      bit          hs;
      bit          de;
      bit [NC-1:0] hit;
      bit          mono;
   } rec_t;

   int   shd [NC][7];
   int   act [NC][7];
   int   cnt20 [NC];
   int   cnt4 [NC];
   int   lat20 [NC];
   int   lat4 [NC];
   rec_t prev_rec;
   rec_t exp_out;
   bit   exp_fd;
   bit   vs_prev;

   function automatic int def_val(input int k, input int f);
      if (k != 0) return 0;
      case (f)
         0: return 'h00;
         1: return 'hFF;
         2: return 'h00;
         3: return 'hFF;
         4: return 'hAF;
         5: return 'hFF;
         default: return 'h01;
      endcase
   endfunction

   function automatic bit strictly_inside(input int lo, input int v, input int hi);
      return (lo < v) && (v < hi);
   endfunction

   function automatic rec_t classify();
      rec_t r;
      bit any_en = 1'b0;
      bit all_en_hit = 1'b1;
      bit any_hit = 1'b0;
      r.vs = ycbcr_vsync;
      r.hs = ycbcr_hsync;
      r.de = ycbcr_de;
      for (int k = 0; k < NC; k++) begin
         bit en  = (act[k][6] & 1) != 0;
         bit yen = (act[k][6] & 2) != 0;
         bit h   = ycbcr_de && en
                 && strictly_inside(act[k][2], int'(cb_data), act[k][3])
                 && strictly_inside(act[k][4], int'(cr_data), act[k][5])
                 && (!yen || strictly_inside(act[k][0], int'(luminance), act[k][1]));
         r.hit[k] = h;
         if (en) begin
            any_en = 1'b1;
            if (!h) all_en_hit = 1'b0;
         end
         if (h) any_hit = 1'b1;
      end
      r.mono = combine_all ? (any_en && all_en_hit) : any_hit;
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) begin
         for (int f = 0; f < 7; f++) begin
            shd[k][f] = def_val(k, f);
            act[k][f] = def_val(k, f);
         end
         cnt20[k] = 0; cnt4[k] = 0; lat20[k] = 0; lat4[k] = 0;
      end
      prev_rec = '{default: 0};
      exp_out  = '{default: 0};
      exp_fd   = 1'b0;
      vs_prev  = 1'b0;
   endtask

   // One clock of the model: the output after this edge is the pixel seen one
   // edge earlier; counts advance by that pixel's hits.
   task automatic model_step();
      rec_t nr;
      bit   vr;
      int   h, c, f;
      nr = classify();
      vr = ycbcr_vsync && !vs_prev;
      exp_out = prev_rec;
      exp_fd  = vr;
      for (int k = 0; k < NC; k++) begin
         h = int'(prev_rec.hit[k]);
         if (vr) begin
            lat20[k] = cnt20[k]; lat4[k] = cnt4[k];
            cnt20[k] = h;        cnt4[k] = h;
         end else begin
            cnt20[k] = (cnt20[k] + h > MAX20) ? MAX20 : cnt20[k] + h;
            cnt4[k]  = (cnt4[k] + h > MAX4) ? MAX4 : cnt4[k] + h;
         end
      end
      if (vr) begin
         for (int k = 0; k < NC; k++)
            for (int j = 0; j < 7; j++) act[k][j] = shd[k][j];
      end
      c = int'(cfg_class);
      f = int'(cfg_field);
      if (cfg_wr && c < NC && f < 7) shd[c][f] = (f == 6) ? (int'(cfg_data) & 3) : int'(cfg_data);
      prev_rec = nr;
      vs_prev  = ycbcr_vsync;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] actual, input logic [63:0] req);
      checks++;
      if (actual !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, actual, req, $time);
      end
   endtask

   task automatic check_model();
      chk("model_monoc",      64'(monoc),        64'(exp_out.mono));
      chk("model_class_hit",  64'(class_hit),    64'(exp_out.hit));
      chk("model_post_sync",  64'({post_vsync, post_hsync, post_de}),
                              64'({exp_out.vs, exp_out.hs, exp_out.de}));
      chk("model_frame_done", 64'(frame_done),   64'(exp_fd));
      chk("model_s_outputs",  64'({monoc_s, class_hit_s, post_vsync_s, post_hsync_s, post_de_s, frame_done_s}),
                              64'({exp_out.mono, exp_out.hit, exp_out.vs, exp_out.hs, exp_out.de, exp_fd}));
      for (int k = 0; k < NC; k++) begin
         chk("model_hit_cnt",     64'(hit_cnt[k*CW +: CW]),     64'(lat20[k]));
         chk("model_hit_cnt_sat", 64'(hit_cnt_s[k*CWS +: CWS]), 64'(lat4[k]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_step();
      else       model_reset();
      @(negedge clk);
      check_model();
   endtask

   task automatic cfg(input int c, input int f, input int d);
      cfg_wr = 1'b1; cfg_class = 3'(c); cfg_field = 3'(f); cfg_data = 8'(d);
      step();
      cfg_wr = 1'b0;
   endtask

   task automatic vsync_pulse();
      ycbcr_vsync = 1'b1; step();
      ycbcr_vsync = 1'b0; step();
   endtask

   // Pixel in, one idle cycle, then its result is on the outputs.
   task automatic send_pixel(input bit comb, input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr, input bit de);
      ycbcr_de = de; combine_all = comb; luminance = y; cb_data = cb; cr_data = cr;
      step();
      ycbcr_de = 1'b0;
      step();
   endtask

   task automatic expect_pix(input string nm, input bit mono, input logic [1:0] ch);
      chk({nm, "_monoc"},     64'(monoc),     64'(mono));
      chk({nm, "_class_hit"}, 64'(class_hit), 64'(ch));
   endtask

   typedef struct {
      bit         de;
      bit         comb;
      logic [7:0] y;
      logic [7:0] cb;
      logic [7:0] cr;
      bit         mono;
      logic [1:0] ch;
   } vec_t;

   vec_t tbl [10];

   // Default thresholds: class 0 cb in (00,FF), cr in (AF,FF), Y ignored; class 1 off.
   task automatic run_table(input string tag);
      for (int i = 0; i < 10; i++) begin
         send_pixel(tbl[i].comb, tbl[i].y, tbl[i].cb, tbl[i].cr, tbl[i].de);
         expect_pix(tag, tbl[i].mono, tbl[i].ch);
         chk({tag, "_post_de"}, 64'(post_de), 64'(tbl[i].de));
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'h10, 8'h80, 8'hB0, 1'b1, 2'b01};
      tbl[1] = '{1'b1, 1'b0, 8'h10, 8'h80, 8'hAF, 1'b0, 2'b00};
      tbl[2] = '{1'b1, 1'b0, 8'h10, 8'h80, 8'hFF, 1'b0, 2'b00};
      tbl[3] = '{1'b0, 1'b0, 8'h10, 8'h80, 8'hB0, 1'b0, 2'b00};
      tbl[4] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hB0, 1'b0, 2'b00};
      tbl[5] = '{1'b1, 1'b0, 8'h10, 8'hFF, 8'hB0, 1'b0, 2'b00};
      tbl[6] = '{1'b1, 1'b0, 8'h10, 8'h01, 8'hFE, 1'b1, 2'b01};
      tbl[7] = '{1'b1, 1'b1, 8'h10, 8'h80, 8'hC0, 1'b1, 2'b01};
      tbl[8] = '{1'b1, 1'b1, 8'h10, 8'h80, 8'hAF, 1'b0, 2'b00};
      tbl[9] = '{1'b1, 1'b0, 8'hFF, 8'h40, 8'hB1, 1'b1, 2'b01};

      checks = 0; failures = 0;
      rst_n = 1'b0;
      ycbcr_vsync = 1'b0; ycbcr_hsync = 1'b0; ycbcr_de = 1'b0;
      luminance = 8'h00; cb_data = 8'h00; cr_data = 8'h00;
      cfg_wr = 1'b0; cfg_class = 3'd0; cfg_field = 3'd0; cfg_data = 8'h00;
      combine_all = 1'b0;
      model_reset();

      // reset state
      @(negedge clk);
      chk("rst_outputs", 64'({monoc, class_hit, post_vsync, post_hsync, post_de, frame_done}), 64'(0));
      chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
      check_model();
      rst_n = 1'b1;
      step();

      // defaults: vector table
      run_table("tbl");

      // class 1 configured mid-frame: invisible until the next frame start
      cfg(1, 2, 'h00); cfg(1, 3, 'hFF); cfg(1, 4, 'h10); cfg(1, 5, 'h50); cfg(1, 6, 'h01);
      send_pixel(1'b0, 8'h10, 8'h80, 8'h30, 1'b1);
      expect_pix("midframe_cfg", 1'b0, 2'b00);
      vsync_pulse();
      send_pixel(1'b0, 8'h10, 8'h80, 8'h30, 1'b1);
      expect_pix("class1_or", 1'b1, 2'b10);
      send_pixel(1'b1, 8'h10, 8'h80, 8'h30, 1'b1);
      expect_pix("class1_and", 1'b0, 2'b10);

      // write landing exactly on the commit cycle
      ycbcr_vsync = 1'b1;
      cfg_wr = 1'b1; cfg_class = 3'd0; cfg_field = 3'd4; cfg_data = 8'h00;
      step();
      cfg_wr = 1'b0; ycbcr_vsync = 1'b0;
      step();
      send_pixel(1'b0, 8'h10, 8'h80, 8'h60, 1'b1);
      expect_pix("commit_race_old", 1'b0, 2'b00);
      vsync_pulse();
      send_pixel(1'b0, 8'h10, 8'h80, 8'h60, 1'b1);
      expect_pix("commit_race_new", 1'b1, 2'b01);

      // 100 class-0 hits in one frame, reported at the next frame start
      vsync_pulse();
      ycbcr_de = 1'b1; cb_data = 8'h80; cr_data = 8'hB0; combine_all = 1'b0;
      for (int i = 0; i < 100; i++) step();
      ycbcr_de = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("pre_commit_no_done", 64'(frame_done), 64'(0));
      ycbcr_vsync = 1'b1;
      step();
      chk("frame_done_pulse", 64'(frame_done), 64'(1));
      chk("hit_cnt_c0_100",   64'(hit_cnt[CW-1:0]), 64'(100));
      chk("hit_cnt_c1_0",     64'(hit_cnt[2*CW-1:CW]), 64'(0));
      chk("hit_cnt_sat_15",   64'(hit_cnt_s[CWS-1:0]), 64'(15));
      step();
      chk("frame_done_1clk",  64'(frame_done), 64'(0));
      ycbcr_vsync = 1'b0;
      ycbcr_de = 1'b1;
      for (int i = 0; i < 10; i++) step();
      ycbcr_de = 1'b0;
      step();
      chk("hit_cnt_stable",     64'(hit_cnt[CW-1:0]), 64'(100));
      chk("hit_cnt_sat_stable", 64'(hit_cnt_s[CWS-1:0]), 64'(15));

      // every class disabled: black in both modes
      cfg(0, 6, 'h00); cfg(1, 6, 'h00);
      vsync_pulse();
      send_pixel(1'b0, 8'h10, 8'h80, 8'hB0, 1'b1);
      expect_pix("all_off_or", 1'b0, 2'b00);
      send_pixel(1'b1, 8'h10, 8'h80, 8'hB0, 1'b1);
      expect_pix("all_off_and", 1'b0, 2'b00);

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         ycbcr_vsync = ($urandom_range(0, 39) == 0);
         ycbcr_hsync = 1'($urandom_range(0, 1));
         ycbcr_de    = ($urandom_range(0, 3) != 0);
         luminance   = 8'($urandom_range(0, 255));
         cb_data     = 8'($urandom_range(0, 255));
         cr_data     = 8'($urandom_range(0, 255));
         combine_all = 1'($urandom_range(0, 1));
         cfg_wr      = ($urandom_range(0, 3) == 0);
         cfg_class   = 3'($urandom_range(0, 2));
         cfg_field   = 3'($urandom_range(0, 7));
         cfg_data    = 8'($urandom_range(0, 255));
         step();
      end
      cfg_wr = 1'b0;

      // asynchronous reset mid-frame with modified thresholds
      ycbcr_de = 1'b1; ycbcr_vsync = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_outputs", 64'({monoc, class_hit, post_vsync, post_hsync, post_de, frame_done}), 64'(0));
      chk("async_rst_hit_cnt", 64'(hit_cnt), 64'(0));
      check_model();
      ycbcr_de = 1'b0; ycbcr_hsync = 1'b0; combine_all = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      run_table("post_rst");
      vsync_pulse();
      send_pixel(1'b0, 8'h10, 8'h80, 8'hB0, 1'b1);
      expect_pix("post_rst_commit", 1'b1, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ycbcr_multi_threshold.md
# ycbcr_multi_threshold

Parametrised colour-segmentation stage between the RGB→YCbCr converter and the downstream blob/centroid logic. It classifies each pixel against NUM_CLASS independent Y/Cb/Cr window sets and emits a 1-bit mono mask plus per-class hit flags. Thresholds are runtime-writable from the UART debug path through shadow registers that commit only at frame start. Per-class pixel-hit counts are reported once per frame.

## Interface
- DW, 8: pixel component width.
- NUM_CLASS, 2: number of threshold classes (1..8).
- CNT_W, 20: per-class frame hit counter width.
- clk  in  1: pixel clock.
- rst_n  in  1: asynchronous, active-low reset.
- ycbcr_vsync / ycbcr_hsync / ycbcr_de  in  1 each: input syncs; vsync is active-high, and its rising edge marks frame start.
- luminance, cb_data, cr_data  in  DW each: pixel components, valid when ycbcr_de=1.
- cfg_wr  in  1: one-cycle write strobe.
- cfg_class  in  3: target class index; writes with index ≥ NUM_CLASS are ignored.
- cfg_field  in  3: 0 y_lo, 1 y_hi, 2 cb_lo, 3 cb_hi, 4 cr_lo, 5 cr_hi, 6 ctrl. Field 7 is ignored.
- cfg_data  in  DW: write data. For ctrl, bit0 = class enable and bit1 = Y-check enable.
- combine_all  in  1: 0 sets monoc = OR of enabled class hits; 1 sets monoc = AND of enabled class hits.
- post_vsync / post_hsync / post_de  out  1 each: input syncs delayed 2 cycles. Reset value 0.
- monoc  out  1: 1 = white, 0 = black. Reset value 0.
- class_hit  out  NUM_CLASS: per-class hit, aligned with monoc. Reset value 0.
- hit_cnt  out  NUM_CLASS*CNT_W: previous-frame hit counts, with class k at bits [k*CNT_W +: CNT_W]. Reset value 0.
- frame_done  out  1: one-cycle pulse when hit_cnt updates. Reset value 0.

## Operation
- Two register banks per class:
  - Shadow bank, written by cfg_wr.
  - Active bank, used for compare.
- Reset values, both banks:
  - Class 0: y 00/FF, cb 00/FF, cr AF/FF, ctrl 01 (enabled, Y check off).
  - All other classes: all fields 0, ctrl 00.
- Commit:
  - vsync_rise = ycbcr_vsync & ~vsync_q, where vsync_q is the registered ycbcr_vsync.
  - On vsync_rise, all active banks load from their shadow banks in the same cycle.
  - If cfg_wr coincides with vsync_rise, the shadow bank takes the new value and the active bank takes the old shadow value. The new value therefore takes effect at the following frame start.
- Compare, per class k:
  - hit_k = en_k & (cb_lo < cb < cb_hi) & (cr_lo < cr < cr_hi) & (~yen_k | (y_lo < y < y_hi)).
  - All comparisons are strict and unsigned, DW wide.
  - If lo ≥ hi, the class can never hit.
- Combine:
  - If no class is enabled, monoc = 0 in both combine modes.
  - AND mode considers enabled classes only.
- Pipeline:
  - Stage 1 registers raw per-class hits, gated with ycbcr_de.
  - Stage 2 registers class_hit and monoc.
  - Pixels with de = 0 produce monoc = 0 and class_hit = 0.
- Counters, per class:
  - Increment on each stage-1 hit, saturating at 2^CNT_W−1.
  - On vsync_rise: hit_cnt latches the counter values, the counters clear to 0, and frame_done is asserted on the next cycle.
  - A hit arriving in the vsync_rise cycle counts toward the new frame.
- Asynchronous reset mid-frame returns all banks, counters and outputs to their reset values immediately. The next vsync_rise then commits defaults again.

## Timing
- Latency: 2 clk from an input pixel to monoc/class_hit/post_*. The syncs use the same 2-stage delay, with no bubbles.
- Throughput: 1 pixel per clk.
- Config writes accept 1 per clk with no backpressure. The last write to a field before vsync_rise wins.
- A threshold change is never visible mid-frame.
- hit_cnt is stable for a whole frame. It changes only at the cycle frame_done is asserted.

## Structure
- The shared package holds:
  - cfg_field encodings (FLD_Y_LO … FLD_CTRL);
  - ctrl bit positions;
  - class-0 default thresholds (CB_LO_DEF=00, CB_HI_DEF=FF, CR_LO_DEF=AF, CR_HI_DEF=FF).
- Sub-module ycbcr_window_cmp: one instance per class via generate. It holds one class's shadow and active banks, the commit logic and the strict-window compare, and outputs the stage-1 hit.
- The top level holds the sync delay line, the combine logic, the counters and the frame_done generation.

## Test plan
- Default thresholds, pixel cb=80/cr=B0, then cr=AF, then cr=FF → monoc 1/0/0, each 2 clk after its pixel; post_de matches ycbcr_de delayed 2.
- Write class 1 cr_lo=10/cr_hi=50 with ctrl=01 mid-frame → no change until the next vsync rise. Then pixel cr=30: class_hit=2'b10 and monoc=1 in OR mode, monoc=0 in AND mode.
- cfg_wr to class 0 cr_lo=00 in the exact vsync_rise cycle → the old AF is still used this frame; the new value takes effect from the next frame.
- 100 hitting pixels in frame N, then vsync rise → frame_done asserted for 1 clk with hit_cnt[class0]=100. Pixels in frame N+1 leave hit_cnt unchanged until the next vsync rise.
- CNT_W=4 with 20 hits → count saturates at 15; set ctrl=00 on all classes → monoc stays 0 in both modes.
- Assert rst_n low mid-frame with modified thresholds → all outputs 0 and defaults restored; after release the defaults behave as in scenario 1.
